// File: rtl/mem_access_ctrl.sv
// Arbitrated word-access controller: serialises 32-bit loads/stores from two ports onto a
// byte-wide 256-entry memory, four little-endian byte beats per aligned word.
module mem_access_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        memWrite0,
   input  logic        memWrite1,
   input  logic [31:0] address0,
   input  logic [31:0] address1,
   input  logic [31:0] write_data0,
   input  logic [31:0] write_data1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] read_data,
   output logic        err,
   output logic        busy,
   output logic [7:0]  mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata
);

   typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        port_q, port_d;
   logic [7:0]  base_q, base_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [23:0] rbuf_q, rbuf_d;
   logic [31:0] read_data_q, read_data_d;
   logic        mis_q, mis_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  mwd_q, mwd_d;

   logic        grant;
   logic [7:0]  sel_addr;
   logic [7:0]  xfer_addr;
   logic [7:0]  xfer_byte;
   logic        unused_addr;

   assign unused_addr = ^{address0[31:8], address1[31:8]};

   // Round-robin: on contention the port not granted last wins.
   assign grant     = (req0 && req1) ? ~last_grant_q : req1;
   assign sel_addr  = grant ? address1[7:0] : address0[7:0];
   assign xfer_addr = {base_q[7:2], cnt_q};
   assign xfer_byte = wdata_q[8*cnt_q +: 8];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      base_d       = base_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      rbuf_d       = rbuf_q;
      read_data_d  = read_data_q;
      mis_d        = mis_q;
      addr_d       = addr_q;
      mwd_d        = mwd_q;
      unique case (state_q)
         StIdle: begin
            if (req0 || req1) begin
               port_d       = grant;
               last_grant_d = grant;
               base_d       = sel_addr;
               write_d      = grant ? memWrite1 : memWrite0;
               wdata_d      = grant ? write_data1 : write_data0;
               cnt_d        = 2'd0;
               mis_d        = |sel_addr[1:0];
               if (|sel_addr[1:0]) begin
                  read_data_d = 32'd0;
                  state_d     = StDone;
               end else begin
                  state_d = StXfer;
               end
            end
         end
         StXfer: begin
            addr_d = xfer_addr;
            mwd_d  = xfer_byte;
            if (!write_q) begin
               case (cnt_q)
                  2'd0:    rbuf_d[7:0]   = mem_rdata;
                  2'd1:    rbuf_d[15:8]  = mem_rdata;
                  2'd2:    rbuf_d[23:16] = mem_rdata;
                  default: ;
               endcase
            end
            if (cnt_q == 2'd3) begin
               // Last beat bypasses the buffer so the word is complete on entry to DONE.
               read_data_d = write_q ? 32'd0 : {mem_rdata, rbuf_q};
               state_d     = StDone;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 2'd0;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         base_q       <= 8'd0;
         write_q      <= 1'b0;
         wdata_q      <= 32'd0;
         rbuf_q       <= 24'd0;
         read_data_q  <= 32'd0;
         mis_q        <= 1'b0;
         addr_q       <= 8'd0;
         mwd_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         base_q       <= base_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         rbuf_q       <= rbuf_d;
         read_data_q  <= read_data_d;
         mis_q        <= mis_d;
         addr_q       <= addr_d;
         mwd_q        <= mwd_d;
      end
   end

   always_comb begin
      ack0      = (state_q == StDone) && !port_q;
      ack1      = (state_q == StDone) && port_q;
      err       = (state_q == StDone) && mis_q;
      busy      = (state_q != StIdle);
      mem_we    = (state_q == StXfer) && write_q;
      mem_addr  = (state_q == StXfer) ? xfer_addr : addr_q;
      mem_wdata = (state_q == StXfer) ? xfer_byte : mwd_q;
      read_data = read_data_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: drivers push expected responses, a monitor pops and
// checks them on every ack against a reference memory and a round-robin arbitration model.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic        memWrite0 = 1'b0, memWrite1 = 1'b0;
   logic [31:0] address0 = '0, address1 = '0;
   logic [31:0] write_data0 = '0, write_data1 = '0;
   logic        ack0, ack1, err, busy, mem_we;
   logic [31:0] read_data;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;

   mem_access_ctrl dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .memWrite0(memWrite0), .memWrite1(memWrite1),
      .address0(address0), .address1(address1),
      .write_data0(write_data0), .write_data1(write_data1),
      .ack0(ack0), .ack1(ack1), .read_data(read_data), .err(err), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   bit [7:0] mem [256];
   bit [7:0] ref_mem [256];
   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] rdata;
      bit          chk_rdata;
      bit          err;
      int          lat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   checks = 0;
   int   fails = 0;
   int   ack_total = 0;
   int   ack_cyc[$];
   bit   ack_port[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a word access is four bytes at {a[7:2], n}, byte n = word bits [8n+7:8n].
   task automatic issue(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d);
      exp_t e;
      bit   got = 0;
      e.err       = (a[1:0] != 2'b00);
      e.lat       = e.err ? 0 : 4;
      e.chk_rdata = e.err || !we;
      e.rdata     = 32'd0;
      if (!e.err) begin
         for (int n = 0; n < 4; n++) begin
            if (we) ref_mem[a[7:0] - a[1:0] + n] = d[8*n +: 8];
            else e.rdata[8*n +: 8] = ref_mem[a[7:0] + n];
         end
      end
      @(posedge clk); #1;
      if (!p) begin
         req0 = 1; memWrite0 = we; address0 = a; write_data0 = d; q0.push_back(e);
      end else begin
         req1 = 1; memWrite1 = we; address1 = a; write_data1 = d; q1.push_back(e);
      end
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (p ? ack1 : ack0) got = 1;
      end
      if (!got) begin
         checks++; fails++;
         $display("FAIL ack_timeout: port %0d got no ack expected ack within 40 cycles", p);
      end
      @(posedge clk); #1;
      if (!p) req0 = 0; else req1 = 0;
   endtask

   // Monitor: arbitration model plus scoreboard pop on every ack.
   initial begin
      bit   last_srv = 1, busy_prev = 0, rq0_prev = 0, rq1_prev = 0, pend = 0, exp_port = 0, p;
      int   start_cyc = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            last_srv = 1; busy_prev = 0; rq0_prev = 0; rq1_prev = 0; pend = 0;
         end else begin
            if (mem_we) check("we_outside_busy", busy, 1);
            if (busy && !busy_prev) begin
               pend      = 1;
               start_cyc = cyc;
               exp_port  = (rq0_prev && rq1_prev) ? ~last_srv : rq1_prev;
            end
            if (ack0 || ack1) begin
               p = ack1;
               ack_total++;
               ack_cyc.push_back(cyc);
               ack_port.push_back(p);
               check("dual_ack", ack0 && ack1, 0);
               check("ack_without_grant", pend, 1);
               check("grant_port", p, exp_port);
               last_srv = p;
               pend     = 0;
               if ((p ? q1.size() : q0.size()) == 0) begin
                  checks++; fails++;
                  $display("FAIL unexpected_ack: port %0d got ack expected none", p);
               end else begin
                  e = p ? q1.pop_front() : q0.pop_front();
                  check("err", err, e.err);
                  check("latency", cyc - start_cyc, e.lat);
                  if (e.chk_rdata) check("read_data", read_data, e.rdata);
               end
            end
            busy_prev = busy; rq0_prev = req0; rq1_prev = req1;
         end
      end
   end

   initial begin
      int acks_before;
      bit [7:0] old42, old43;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack0", ack0, 0);
      check("rst_ack1", ack1, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_read_data", read_data, 0);
      @(posedge clk); #1 reset = 0;

      // Contention from reset: expect 0, 1, 0 with acks six cycles apart.
      ack_cyc.delete(); ack_port.delete();
      fork
         begin
            issue(0, 1, 32'h0000_0020, 32'h1234_5678);
            issue(0, 0, 32'h0000_0020, 32'h0);
         end
         issue(1, 1, 32'h0000_00A0, 32'hCAFE_F00D);
      join
      check("cont_acks", ack_cyc.size(), 3);
      if (ack_cyc.size() == 3) begin
         check("cont_order0", ack_port[0], 0);
         check("cont_order1", ack_port[1], 1);
         check("cont_order2", ack_port[2], 0);
         check("cont_gap01", ack_cyc[1] - ack_cyc[0], 6);
         check("cont_gap12", ack_cyc[2] - ack_cyc[1], 6);
      end

      // Store then load of a known word.
      issue(0, 1, 32'h0000_0010, 32'hAABB_CCDD);
      check("st_b0", mem[8'h10], 8'hDD);
      check("st_b1", mem[8'h11], 8'hCC);
      check("st_b2", mem[8'h12], 8'hBB);
      check("st_b3", mem[8'h13], 8'hAA);
      issue(1, 0, 32'h0000_0010, 32'h0);

      // Misaligned accesses and top-of-memory word with junk upper address bits.
      issue(0, 1, 32'h0000_0013, 32'h5555_5555);
      issue(1, 0, 32'h0000_0092, 32'h0);
      issue(1, 1, 32'hFFFF_FFFC, 32'h0102_0304);
      issue(1, 0, 32'hFFFF_FFFC, 32'h0);

      // Reset in the third store beat: bytes 0..1 land, nothing else, no ack.
      old42 = mem[8'h42]; old43 = mem[8'h43];
      acks_before = ack_total;
      @(posedge clk); #1;
      req0 = 1; memWrite0 = 1; address0 = 32'h40; write_data0 = 32'h1122_3344;
      repeat (3) @(posedge clk);
      #1;
      check("mid_we", mem_we, 1);
      check("mid_addr", mem_addr, 8'h42);
      #1 reset = 1;
      #1;
      check("rst_mid_we", mem_we, 0);
      check("rst_mid_busy", busy, 0);
      req0 = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;
      check("rst_mid_b0", mem[8'h40], 8'h44);
      check("rst_mid_b1", mem[8'h41], 8'h33);
      check("rst_mid_b2", mem[8'h42], old42);
      check("rst_mid_b3", mem[8'h43], old43);
      check("rst_mid_noack", ack_total - acks_before, 0);
      ref_mem[8'h40] = 8'h44;
      ref_mem[8'h41] = 8'h33;
      issue(0, 0, 32'h0000_0040, 32'h0);

      // Random traffic; port 0 owns addresses 0x00-0x7F, port 1 owns 0x80-0xFF.
      fork
         for (int i = 0; i < 30; i++) begin
            logic [31:0] a0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a0 = {$urandom_range(0, 32'hFF_FFFF), 1'b0, 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 3) != 0) a0[1:0] = 2'b00;
            issue(0, 1'($urandom_range(0, 1)), a0, $urandom);
         end
         for (int j = 0; j < 30; j++) begin
            logic [31:0] a1;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            a1 = {$urandom_range(0, 32'hFF_FFFF), 1'b1, 7'($urandom_range(0, 127))};
            if ($urandom_range(0, 3) != 0) a1[1:0] = 2'b00;
            issue(1, 1'($urandom_range(0, 1)), a1, $urandom);
         end
      join

      repeat (4) @(posedge clk);
      for (int b = 0; b < 256; b++) check($sformatf("mem_%02h", b), mem[b], ref_mem[b]);
      check("q0_drained", q0.size(), 0);
      check("q1_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
